// File: rtl/i2c_slave_read_ctrl.sv
// I2C slave bit/byte receive engine with START/STOP error detection.
// Optional I2C_SLAVE_READ_SYNC_EN adds 2-flop synchronizers on scl_i/sda_i.
module i2c_slave_read_ctrl #(
    parameter int BYTE_BITS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rd_en,
    input  logic is_byte,
    output logic rd_ld,
    output logic data_o,
    output logic rd_finish,
    output logic get_start,
    output logic get_stop,
    output logic rd_err,
    input  logic scl_i,
    input  logic sda_i
);

    localparam int CW = $clog2(BYTE_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_t;

    logic scl;
    logic sda;

`ifdef I2C_SLAVE_READ_SYNC_EN
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

    assign scl = scl_sync[1];
    assign sda = sda_sync[1];
`else
    assign scl = scl_i;
    assign sda = sda_i;
`endif

    logic scl_d;
    logic sda_d;
    logic scl_rise;
    logic scl_fall;
    logic sda_rise;
    logic sda_fall;

    // SDA edges only count as START/STOP when SCL is stable high
    assign scl_rise = scl & ~scl_d;
    assign scl_fall = ~scl & scl_d;
    assign sda_fall = scl & scl_d & ~sda & sda_d;
    assign sda_rise = scl & scl_d & sda & ~sda_d;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] target;
    logic [CW-1:0] target_nxt;
    logic          err_flag;
    logic          err_flag_nxt;
    logic          ld_nxt;
    logic          data_nxt;
    logic          finish_nxt;
    logic          rerr_nxt;
    logic          start_nxt;
    logic          stop_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            target    <= '0;
            err_flag  <= 1'b0;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            rd_ld     <= 1'b0;
            data_o    <= 1'b0;
            rd_finish <= 1'b0;
            rd_err    <= 1'b0;
            get_start <= 1'b0;
            get_stop  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            target    <= target_nxt;
            err_flag  <= err_flag_nxt;
            scl_d     <= scl;
            sda_d     <= sda;
            rd_ld     <= ld_nxt;
            data_o    <= data_nxt;
            rd_finish <= finish_nxt;
            rd_err    <= rerr_nxt;
            get_start <= start_nxt;
            get_stop  <= stop_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        target_nxt   = target;
        err_flag_nxt = err_flag;
        ld_nxt       = 1'b0;
        data_nxt     = data_o;
        finish_nxt   = 1'b0;
        rerr_nxt     = 1'b0;
        start_nxt    = 1'b0;
        stop_nxt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_en) begin
                    target_nxt   = is_byte ? CW'(BYTE_BITS) : CW'(1);
                    cnt_nxt      = '0;
                    err_flag_nxt = 1'b0;
                    state_nxt    = RECV;
                end
            end
            RECV: begin
                if (!rd_en) begin
                    state_nxt = IDLE;
                end else begin
                    if (scl_rise) begin
                        data_nxt = sda;
                        ld_nxt   = 1'b1;
                        cnt_nxt  = cnt + CW'(1);
                    end
                    if (sda_fall) begin
                        start_nxt    = 1'b1;
                        err_flag_nxt = 1'b1;
                    end
                    if (sda_rise) begin
                        stop_nxt     = 1'b1;
                        err_flag_nxt = 1'b1;
                    end
                    if (scl_fall && cnt == target) begin
                        finish_nxt = 1'b1;
                        rerr_nxt   = err_flag;
                        state_nxt  = DONE;
                    end
                end
            end
            DONE: begin
                if (!rd_en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_slave_read_ctrl.sv
// Directed bench for i2c_slave_read_ctrl: bit/byte receive, error
// detection, handshake and mid-transfer reset.
module tb_i2c_slave_read_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic rd_en;
    logic is_byte;
    logic rd_ld;
    logic data_o;
    logic rd_finish;
    logic get_start;
    logic get_stop;
    logic rd_err;
    logic scl_i;
    logic sda_i;

    int vecs = 0;
    int errs = 0;

    int       n_ld = 0;
    int       n_fin = 0;
    int       n_start = 0;
    int       n_stop = 0;
    logic     last_err = 1'b0;
    logic [7:0] shreg = 8'h00;

    int b_ld, b_fin, b_start, b_stop;

    i2c_slave_read_ctrl #(.BYTE_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .is_byte   (is_byte),
        .rd_ld     (rd_ld),
        .data_o    (data_o),
        .rd_finish (rd_finish),
        .get_start (get_start),
        .get_stop  (get_stop),
        .rd_err    (rd_err),
        .scl_i     (scl_i),
        .sda_i     (sda_i)
    );

    always #5 clk = ~clk;

    // Consumer model: MSB-first shifter plus pulse counters
    always @(negedge clk) begin
        if (rd_ld) begin
            n_ld  <= n_ld + 1;
            shreg <= {shreg[6:0], data_o};
        end
        if (rd_finish) begin
            n_fin    <= n_fin + 1;
            last_err <= rd_err;
        end
        if (get_start) n_start <= n_start + 1;
        if (get_stop) n_stop <= n_stop + 1;
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_ld    = n_ld;
        b_fin   = n_fin;
        b_start = n_start;
        b_stop  = n_stop;
    endtask

    // SCL low 2 clk, high 2 clk; optional SDA flip in the middle of high
    task automatic send_bit(input logic b, input logic flip);
        @(negedge clk) sda_i = b;
        @(negedge clk) scl_i = 1'b1;
        @(negedge clk) if (flip) sda_i = ~b;
        @(negedge clk) scl_i = 1'b0;
    endtask

    task automatic xfer(input logic bm, input logic [7:0] d, input int fpos);
        int nb;
        @(negedge clk);
        is_byte = bm;
        rd_en   = 1'b1;
        nb = bm ? 8 : 1;
        for (int i = 0; i < nb; i++)
            send_bit(bm ? d[7-i] : d[0], i == fpos);
        clk_n(6);
    endtask

    task automatic release_en();
        @(negedge clk) rd_en = 1'b0;
        clk_n(3);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        vecs++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        outs = {rd_ld, data_o, rd_finish, get_start, get_stop, rd_err};
        vecs++;
        if (outs !== 6'b0) begin
            errs++;
            $display("FAIL reset_outs: got %b want 000000", outs);
        end
    endtask

    task automatic test_bit();
        snap();
        xfer(1'b0, 8'h01, -1);
        vecs++;
        if (n_ld - b_ld !== 1) begin
            errs++;
            $display("FAIL bit_ld: got %0d want 1", n_ld - b_ld);
        end
        vecs++;
        if (data_o !== 1'b1) begin
            errs++;
            $display("FAIL bit_data: got %b want 1", data_o);
        end
        vecs++;
        if (n_fin - b_fin !== 1) begin
            errs++;
            $display("FAIL bit_fin: got %0d want 1", n_fin - b_fin);
        end
        vecs++;
        if (last_err !== 1'b0) begin
            errs++;
            $display("FAIL bit_err: got %b want 0", last_err);
        end
        vecs++;
        if ((n_start - b_start) + (n_stop - b_stop) !== 0) begin
            errs++;
            $display("FAIL bit_ss: got %0d want 0",
                     (n_start - b_start) + (n_stop - b_stop));
        end
        release_en();
    endtask

    task automatic test_byte();
        snap();
        xfer(1'b1, 8'hA5, -1);
        vecs++;
        if (n_ld - b_ld !== 8) begin
            errs++;
            $display("FAIL byte_ld: got %0d want 8", n_ld - b_ld);
        end
        vecs++;
        if (shreg !== 8'hA5) begin
            errs++;
            $display("FAIL byte_data: got %h want a5", shreg);
        end
        vecs++;
        if (n_fin - b_fin !== 1) begin
            errs++;
            $display("FAIL byte_fin: got %0d want 1", n_fin - b_fin);
        end
        vecs++;
        if (last_err !== 1'b0) begin
            errs++;
            $display("FAIL byte_err: got %b want 0", last_err);
        end
        release_en();
    endtask

    task automatic test_bit_err();
        snap();
        xfer(1'b0, 8'h01, 0);
        vecs++;
        if (n_start - b_start !== 1) begin
            errs++;
            $display("FAIL biterr_start: got %0d want 1", n_start - b_start);
        end
        vecs++;
        if (n_fin - b_fin !== 1 || last_err !== 1'b1) begin
            errs++;
            $display("FAIL biterr_fin: got fin=%0d err=%b want 1/1",
                     n_fin - b_fin, last_err);
        end
        release_en();
    endtask

    task automatic test_byte_err();
        logic [7:0] d;
        logic       b;
        d = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            b = d[7-k];
            snap();
            xfer(1'b1, d, k);
            vecs++;
            if (n_start - b_start !== int'(b) ||
                n_stop - b_stop !== int'(!b)) begin
                errs++;
                $display("FAIL byteerr_ss k=%0d: got start=%0d stop=%0d want %0d/%0d",
                         k, n_start - b_start, n_stop - b_stop, b, !b);
            end
            vecs++;
            if (n_ld - b_ld !== 8 || shreg !== d) begin
                errs++;
                $display("FAIL byteerr_data k=%0d: got ld=%0d data=%h want 8/a5",
                         k, n_ld - b_ld, shreg);
            end
            vecs++;
            if (n_fin - b_fin !== 1 || last_err !== 1'b1) begin
                errs++;
                $display("FAIL byteerr_fin k=%0d: got fin=%0d err=%b want 1/1",
                         k, n_fin - b_fin, last_err);
            end
            release_en();
        end
    endtask

    task automatic test_handshake();
        xfer(1'b1, 8'hC3, 2);
        snap();
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
        clk_n(6);
        chk("hs_hold_ld", n_ld - b_ld, 0);
        chk("hs_hold_fin", n_fin - b_fin, 0);
        release_en();
        snap();
        xfer(1'b1, 8'h5A, -1);
        chk("hs_new_fin", n_fin - b_fin, 1);
        chk("hs_new_err", int'(last_err), 0);
        chk("hs_new_data", int'(shreg), 8'h5A);
        release_en();
    endtask

    task automatic test_idle_quiet();
        snap();
        @(negedge clk) scl_i = 1'b1;
        @(negedge clk) sda_i = 1'b1;
        @(negedge clk) sda_i = 1'b0;
        @(negedge clk) sda_i = 1'b1;
        @(negedge clk) scl_i = 1'b0;
        clk_n(4);
        chk("idle_start", n_start - b_start, 0);
        chk("idle_stop", n_stop - b_stop, 0);
        chk("idle_ld", n_ld - b_ld, 0);
    endtask

    task automatic test_reset_mid();
        snap();
        @(negedge clk);
        is_byte = 1'b1;
        rd_en   = 1'b1;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        test_reset();
        rst   = 1'b0;
        rd_en = 1'b0;
        clk_n(6);
        chk("rstmid_fin", n_fin - b_fin, 0);
        snap();
        xfer(1'b1, 8'h3C, -1);
        chk("rstmid_ld", n_ld - b_ld, 8);
        chk("rstmid_data", int'(shreg), 8'h3C);
        chk("rstmid_fin2", n_fin - b_fin, 1);
        chk("rstmid_err", int'(last_err), 0);
        release_en();
    endtask

    initial begin
        rst     = 1'b1;
        rd_en   = 1'b0;
        is_byte = 1'b0;
        scl_i   = 1'b1;
        sda_i   = 1'b1;
        clk_n(3);
        test_reset();
        rst = 1'b0;
        clk_n(2);
        scl_i = 1'b0;
        clk_n(4);
        test_bit();
        test_byte();
        test_bit_err();
        test_byte_err();
        test_handshake();
        test_idle_quiet();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/i2c_slave_read_ctrl.md
Name: i2c_slave_read_ctrl

Overview:
- Bit/byte receive engine for an I2C slave.
- Samples SDA on each SCL rising edge and streams each sampled bit out with a one-cycle load strobe to an external shift register.
- Detects START/STOP conditions (SDA edge while SCL high) during the transfer and reports them as errors.
- Controlled by the slave FSM through a rd_en / rd_finish handshake.

Parameters:
- BYTE_BITS, 8, number of bits received when is_byte=1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  request a receive; held high until rd_finish has pulsed.
- is_byte  in  1  1 = receive BYTE_BITS bits, 0 = receive 1 bit; sampled when transfer starts.
- rd_ld  out  1  one-cycle strobe, data_o valid; consumer shifts data_o in MSB-first.
- data_o  out  1  last sampled SDA bit.
- rd_finish  out  1  one-cycle pulse at end of transfer.
- get_start  out  1  one-cycle pulse: SDA fell while SCL high.
- get_stop  out  1  one-cycle pulse: SDA rose while SCL high.
- rd_err  out  1  valid with rd_finish: 1 if any START/STOP was seen during the transfer.
- scl_i  in  1  I2C clock input.
- sda_i  in  1  I2C data input.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, bit counter 0, error flag 0, edge-detect registers loaded to 1 (bus idle).
- Edge detect: scl_d and sda_d are registered copies of the inputs.
  - SCL rise = scl & ~scl_d; SCL fall = ~scl & scl_d.
  - SDA fall/rise qualified by scl & scl_d (SCL high on both samples).
- States: IDLE, RECV, DONE.
- IDLE:
  - When rd_en=1: latch bit target (is_byte ? BYTE_BITS : 1), clear counter and error flag, go to RECV.
  - rd_en is asserted while SCL is low, one clk after the SCL fall.
- RECV, on SCL rise:
  - data_o <= sda_i; rd_ld=1 for one cycle; counter++.
  - Bits arrive MSB first.
- RECV, on SDA fall with SCL high: get_start=1 for one cycle; error flag set.
- RECV, on SDA rise with SCL high: get_stop=1 for one cycle; error flag set.
- RECV after an error: sampling and rd_ld continue; the transfer is not shortened.
- RECV end: on the first SCL fall with counter == target, assert rd_finish=1 and rd_err=error flag for one cycle, then go to DONE.
- RECV abort: rd_en=0 returns to IDLE with no rd_finish.
- DONE: outputs idle; return to IDLE when rd_en=0. This prevents retrigger while the requester is still dropping rd_en.
- Latency:
  - rd_ld asserts 1 clk after the SCL rise reaches scl_i; 1+2 clk with the sync option.
  - rd_finish asserts 1 clk after the final SCL fall.
- Simultaneous events:
  - SCL rise and SDA change in the same cycle: treated as data, not START/STOP.
  - SCL fall and SDA change in the same cycle: treated as data.
- Reset mid-transfer: immediate return to IDLE; all outputs 0; no rd_finish.
- Outside RECV, SDA/SCL activity produces no output pulses.
- data_o holds its value between strobes.

Optional Feature:
- Macro I2C_SLAVE_READ_SYNC_EN.
- Defined: scl_i and sda_i each pass through a 2-flop synchronizer (reset value 1) before edge detection. All SCL/SDA-derived events are delayed 2 clk; sampling relationships are unchanged.
- Undefined: inputs go directly to the edge-detect registers.
- The bench timing (SCL low 2 clk, high 2 clk) must pass in both builds.

Test Plan:
- Bit receive: rd_en=1, is_byte=0, SDA=1 before the SCL rise → one rd_ld with data_o=1; rd_finish pulse after the SCL fall; rd_err=0; no get_start/get_stop.
- Byte receive: is_byte=1, data 8'hA5 MSB-first over 8 SCL pulses → 8 rd_ld strobes; shifter=8'hA5; single rd_finish after the 8th SCL fall; rd_err=0.
- Bit with error: SDA toggles 1→0 mid SCL-high → get_start pulse; rd_finish with rd_err=1 after the SCL fall.
- Byte with error at each position 0..7: SDA flipped mid-high on bit k → get_start or get_stop pulse matching the edge direction; transfer still ends after the 8th SCL fall; rd_finish with rd_err=1.
- Handshake: hold rd_en high after rd_finish → no second transfer; drop rd_en, reassert → new transfer starts; error flag is cleared.
- Reset mid-byte after 3 bits: assert rst → outputs 0; no rd_finish; next full byte 8'h3C received correctly.
